// File: rtl/lsu_pkg.sv
// Shared size codes and FSM state encoding for the LSU data-memory master.
package lsu_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_RMW_RD,
    ST_WR,
    ST_RESP,
    ST_ERR
  } state_e;

endpackage

// File: rtl/lsu_align.sv
// Lane handling: load-side extraction/extension and store-side merge into an old word.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  lane_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] merged_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (lane_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    half_sel = lane_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    case (size_i)
      SZ_B:    load_o = {{24{byte_sel[7] & ~unsigned_i}}, byte_sel};
      SZ_H:    load_o = {{16{half_sel[15] & ~unsigned_i}}, half_sel};
      default: load_o = rdata_i;
    endcase

    // Only the addressed lane is replaced; the rest of the old word survives.
    merged_o = rdata_i;
    if (size_i == SZ_B) begin
      case (lane_i)
        2'd0:    merged_o[7:0]   = wdata_i[7:0];
        2'd1:    merged_o[15:8]  = wdata_i[7:0];
        2'd2:    merged_o[23:16] = wdata_i[7:0];
        default: merged_o[31:24] = wdata_i[7:0];
      endcase
    end else if (size_i == SZ_H) begin
      if (lane_i[1]) merged_o[31:16] = wdata_i[15:0];
      else           merged_o[15:0]  = wdata_i[15:0];
    end else begin
      merged_o = wdata_i;
    end
  end

endmodule

// File: rtl/lsu_data_master.sv
// One-at-a-time load/store initiator for a word-addressed SRAM without byte enables.
// state  | meaning
// IDLE   | ready, waiting for a request
// RD     | load read cycle, result captured at end
// RMW_RD | sub-word store: read old word and merge
// WR     | write cycle, SRAM commits on closing edge
// RESP   | completion pulse
// ERR    | completion pulse with error
module lsu_data_master
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 10,
  parameter int unsigned AW        = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          lsu_req_i,
  input  logic          lsu_we_i,
  input  logic [1:0]    lsu_size_i,
  input  logic          lsu_unsigned_i,
  input  logic [31:0]   lsu_addr_i,
  input  logic [31:0]   lsu_wdata_i,
  output logic          lsu_ready_o,
  output logic          lsu_valid_o,
  output logic          lsu_err_o,
  output logic [31:0]   lsu_rdata_o,
  output logic          data_req_o,
  output logic          data_we_o,
  output logic [AW-1:0] data_addr_o,
  output logic [31:0]   data_wdata_o,
  input  logic [31:0]   data_rdata_i
);

  state_e        state_q, state_d;
  logic [1:0]    size_q, size_d;
  logic [1:0]    lane_q, lane_d;
  logic          uns_q, uns_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   wbuf_q, wbuf_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;
  logic          req_q, req_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;

  logic [29:0]   req_widx;
  logic          req_bad;
  logic [31:0]   load_res;
  logic [31:0]   merged;

  lsu_align u_align (
    .rdata_i    (data_rdata_i),
    .lane_i     (lane_q),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .wdata_i    (wdata_q),
    .load_o     (load_res),
    .merged_o   (merged)
  );

  assign req_widx = lsu_addr_i[31:2];
  assign req_bad  = (lsu_size_i == 2'b11)
                  || (lsu_size_i == SZ_H && lsu_addr_i[0])
                  || (lsu_size_i == SZ_W && lsu_addr_i[1:0] != 2'b00)
                  || (req_widx >= 30'(MEM_WORDS));

  always_comb begin
    state_d = state_q;
    size_d  = size_q;
    lane_d  = lane_q;
    uns_d   = uns_q;
    wdata_d = wdata_q;
    wbuf_d  = wbuf_q;
    rdata_d = rdata_q;
    addr_d  = addr_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    req_d   = 1'b0;
    we_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (lsu_req_i) begin
          size_d  = lsu_size_i;
          lane_d  = lsu_addr_i[1:0];
          uns_d   = lsu_unsigned_i;
          wdata_d = lsu_wdata_i;
          if (req_bad) begin
            state_d = ST_ERR;
            valid_d = 1'b1;
            err_d   = 1'b1;
          end else begin
            addr_d = AW'(req_widx);
            req_d  = 1'b1;
            if (!lsu_we_i) begin
              state_d = ST_RD;
            end else if (lsu_size_i == SZ_W) begin
              state_d = ST_WR;
              we_d    = 1'b1;
              wbuf_d  = lsu_wdata_i;
            end else begin
              state_d = ST_RMW_RD;
            end
          end
        end
      end
      ST_RD: begin
        rdata_d = load_res;
        valid_d = 1'b1;
        state_d = ST_RESP;
      end
      ST_RMW_RD: begin
        wbuf_d  = merged;
        req_d   = 1'b1;
        we_d    = 1'b1;
        state_d = ST_WR;
      end
      ST_WR: begin
        valid_d = 1'b1;
        state_d = ST_RESP;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      size_q  <= SZ_B;
      lane_q  <= 2'b00;
      uns_q   <= 1'b0;
      wdata_q <= '0;
      wbuf_q  <= '0;
      rdata_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      size_q  <= size_d;
      lane_q  <= lane_d;
      uns_q   <= uns_d;
      wdata_q <= wdata_d;
      wbuf_q  <= wbuf_d;
      rdata_q <= rdata_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
    end
  end

  assign lsu_ready_o  = (state_q == ST_IDLE);
  assign lsu_valid_o  = valid_q;
  assign lsu_err_o    = err_q;
  assign lsu_rdata_o  = rdata_q;
  assign data_req_o   = req_q;
  assign data_we_o    = we_q;
  assign data_addr_o  = addr_q;
  assign data_wdata_o = wbuf_q;

endmodule
